// File: rtl/slice_tracker.sv
// -----------------------------------------------------------------------------
// slice_tracker
//
// Purpose:
//   N-channel slice detector. Compares the cursor pixel stream with each
//   fruit pixel stream and declares a slice once HIT_THRESH overlapping pixels
//   have been seen within one video frame. The per-frame debounce keeps
//   single-pixel grazes from counting. Each channel holds a sliced level and
//   raises a one-cycle slice pulse. A saturating score totals all slices.
//
// Optional feature (macro COMBO_BONUS_EN):
//   When defined, a frame that ended with two or more slices awards a bonus of
//   (frame_slices - 1) points on the following frame_start.
//   When undefined, the score counts slices only and the per-frame slice
//   counter is not built.
//
// Ports:
//   clk           in   system clock
//   rst_n         in   asynchronous active-low reset
//   frame_start   in   one-cycle pulse at the start of each frame
//   cursor_pix    in   cursor pixel, nonzero = cursor present
//   fruit_pix     in   fruit pixels, channel i at [i*PIX_W +: PIX_W]
//   fruit_active  in   fruit i is on screen
//   fruit_new     in   fruit i respawned, re-arms the channel
//   sliced        out  channel i is in the SLICED state
//   slice_pulse   out  one-cycle pulse on entry to SLICED
//   score         out  saturating total of slices
//
// Channel FSM:
//   state    | meaning
//   ---------+----------------------------------------------------------
//   S_IDLE   | fruit absent or not yet armed; overlap ignored
//   S_ARMED  | counting overlapping pixels in the current frame
//   S_SLICED | threshold reached; holds until respawn or fruit leaves
// -----------------------------------------------------------------------------
module slice_tracker #(
  parameter int NUM_FRUIT  = 3,
  parameter int PIX_W      = 24,
  parameter int HIT_THRESH = 4,
  parameter int SCORE_W    = 10
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       frame_start,
  input  logic [PIX_W-1:0]           cursor_pix,
  input  logic [NUM_FRUIT*PIX_W-1:0] fruit_pix,
  input  logic [NUM_FRUIT-1:0]       fruit_active,
  input  logic [NUM_FRUIT-1:0]       fruit_new,
  output logic [NUM_FRUIT-1:0]       sliced,
  output logic [NUM_FRUIT-1:0]       slice_pulse,
  output logic [SCORE_W-1:0]         score
);

  // Hit counter width holds 0..HIT_THRESH.
  localparam int CW    = $clog2(HIT_THRESH + 1);
  // Popcount width holds 0..NUM_FRUIT.
  localparam int PW    = $clog2(NUM_FRUIT + 1);
  // Per-frame slice counter width.
  localparam int FW    = PW + 1;
  // Score adder width: wide enough for score + popcount + bonus without wrap.
  localparam int SUM_W = SCORE_W + FW + 1;

  localparam logic [CW:0]      THRESH_V  = (CW + 1)'(HIT_THRESH);
  localparam logic [SUM_W-1:0] SCORE_MAX = {{(SUM_W - SCORE_W){1'b0}}, {SCORE_W{1'b1}}};

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ARMED  = 2'd1,
    S_SLICED = 2'd2
  } state_e;

  state_e               state_q [NUM_FRUIT];
  state_e               state_d [NUM_FRUIT];
  logic [CW-1:0]        cnt_q   [NUM_FRUIT];
  logic [CW-1:0]        cnt_d   [NUM_FRUIT];
  logic [NUM_FRUIT-1:0] pulse_q;
  logic [NUM_FRUIT-1:0] pulse_d;
  logic [SCORE_W-1:0]   score_q;
  logic [SCORE_W-1:0]   score_d;

  logic                 cursor_on;
  logic [NUM_FRUIT-1:0] ovl;
  logic [CW:0]          cnt_upd;
  logic [PW-1:0]        slice_cnt;
  logic [FW-1:0]        bonus;
  logic [SUM_W-1:0]     score_sum;

  // ---------------------------------------------------------------------------
  // Overlap detect
  // ---------------------------------------------------------------------------
  assign cursor_on = |cursor_pix;

  always_comb begin
    ovl = '0;
    for (int i = 0; i < NUM_FRUIT; i++) begin
      ovl[i] = cursor_on & (|fruit_pix[i*PIX_W +: PIX_W]) & fruit_active[i];
    end
  end

  // ---------------------------------------------------------------------------
  // Channel FSMs: next state, hit counter, slice pulse
  // ---------------------------------------------------------------------------
  always_comb begin
    pulse_d = '0;
    cnt_upd = '0;
    for (int i = 0; i < NUM_FRUIT; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      if (!fruit_active[i]) begin
        state_d[i] = S_IDLE;
        cnt_d[i]   = '0;
      end else if (fruit_new[i]) begin
        // Respawn wins over any overlap seen in the same cycle.
        state_d[i] = S_ARMED;
        cnt_d[i]   = '0;
      end else begin
        unique case (state_q[i])
          S_ARMED: begin
            // frame_start restarts the count, but this cycle's pixel still counts.
            cnt_upd  = (frame_start ? '0 : {1'b0, cnt_q[i]}) + (CW + 1)'(ovl[i]);
            // cnt_upd never exceeds HIT_THRESH, so it fits in CW bits.
            cnt_d[i] = cnt_upd[CW-1:0];
            if (cnt_upd >= THRESH_V) begin
              state_d[i] = S_SLICED;
              pulse_d[i] = 1'b1;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Score: counts pulses in the same edge that raises them
  // ---------------------------------------------------------------------------
  always_comb begin
    slice_cnt = '0;
    for (int i = 0; i < NUM_FRUIT; i++) begin
      slice_cnt = slice_cnt + PW'(pulse_d[i]);
    end
  end

`ifdef COMBO_BONUS_EN
  logic [FW-1:0] fs_q;
  logic [FW-1:0] fs_d;
  logic [FW:0]   fs_sum;

  // Bonus is based on the frame that just ended, i.e. the count before the clear.
  assign bonus = (frame_start && (fs_q >= FW'(2))) ? (fs_q - FW'(1)) : '0;

  always_comb begin
    // Slices in the frame_start cycle belong to the new frame.
    fs_sum = (frame_start ? '0 : {1'b0, fs_q}) + (FW + 1)'(slice_cnt);
    fs_d   = fs_sum[FW] ? {FW{1'b1}} : fs_sum[FW-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fs_q <= '0;
    end else begin
      fs_q <= fs_d;
    end
  end
`else
  assign bonus = '0;
`endif

  always_comb begin
    score_sum = SUM_W'(score_q) + SUM_W'(slice_cnt) + SUM_W'(bonus);
    score_d   = (score_sum > SCORE_MAX) ? {SCORE_W{1'b1}} : score_sum[SCORE_W-1:0];
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_FRUIT; i++) begin
        state_q[i] <= S_IDLE;
        cnt_q[i]   <= '0;
      end
      pulse_q <= '0;
      score_q <= '0;
    end else begin
      for (int i = 0; i < NUM_FRUIT; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      pulse_q <= pulse_d;
      score_q <= score_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs (all decoded from registers)
  // ---------------------------------------------------------------------------
  always_comb begin
    sliced = '0;
    for (int i = 0; i < NUM_FRUIT; i++) begin
      sliced[i] = (state_q[i] == S_SLICED);
    end
  end

  assign slice_pulse = pulse_q;
  assign score       = score_q;

endmodule

// File: tb/tb_slice_tracker.sv
module tb_slice_tracker;

  localparam int NF    = 3;
  localparam int PW    = 24;
  localparam int TH    = 4;
  localparam int SW    = 10;
  localparam int SMAX  = (1 << SW) - 1;
  localparam int FSMAX = 7;

`ifdef COMBO_BONUS_EN
  localparam bit COMBO = 1'b1;
`else
  localparam bit COMBO = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n;
  logic             frame_start;
  logic [PW-1:0]    cursor_pix;
  logic [NF*PW-1:0] fruit_pix;
  logic [NF-1:0]    fruit_active;
  logic [NF-1:0]    fruit_new;
  logic [NF-1:0]    sliced;
  logic [NF-1:0]    slice_pulse;
  logic [SW-1:0]    score;

  always #5 clk = ~clk;

  slice_tracker #(
    .NUM_FRUIT (NF),
    .PIX_W     (PW),
    .HIT_THRESH(TH),
    .SCORE_W   (SW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .frame_start (frame_start),
    .cursor_pix  (cursor_pix),
    .fruit_pix   (fruit_pix),
    .fruit_active(fruit_active),
    .fruit_new   (fruit_new),
    .sliced      (sliced),
    .slice_pulse (slice_pulse),
    .score       (score)
  );

  // stimulus vector: frame_start, active, new, fruit pixel mask, cursor on
  typedef struct packed {
    logic          fs;
    logic [NF-1:0] act;
    logic [NF-1:0] nw;
    logic [NF-1:0] pix;
    logic          cur;
  } stim_t;

  typedef logic [NF+NF+SW-1:0] exp_t;   // {sliced, slice_pulse, score}

  exp_t sb_q[$];
  exp_t exp_v;
  int   n_vec = 0;
  int   n_err = 0;

  // reference model: 0 idle, 1 armed, 2 sliced
  int m_state [NF];
  int m_cnt   [NF];
  int m_score;
  int m_fs;

  task automatic model_reset();
    for (int i = 0; i < NF; i++) begin
      m_state[i] = 0;
      m_cnt[i]   = 0;
    end
    m_score = 0;
    m_fs    = 0;
    sb_q.delete();
  endtask

  task automatic model_step();
    logic [NF-1:0] pulse;
    logic [NF-1:0] sl;
    int            pop;
    int            bonus;
    bit            ov;
    pulse = '0;
    for (int i = 0; i < NF; i++) begin
      ov = (cursor_pix != 0) && (fruit_pix[i*PW +: PW] != 0) && fruit_active[i];
      if (!fruit_active[i]) begin
        m_state[i] = 0;
        m_cnt[i]   = 0;
      end else if (fruit_new[i]) begin
        m_state[i] = 1;
        m_cnt[i]   = 0;
      end else if (m_state[i] == 1) begin
        if (frame_start) m_cnt[i] = 0;
        if (ov) m_cnt[i] = m_cnt[i] + 1;
        if (m_cnt[i] >= TH) begin
          m_state[i] = 2;
          pulse[i]   = 1'b1;
        end
      end
    end
    pop   = $countones(pulse);
    bonus = 0;
    if (COMBO && frame_start && m_fs >= 2) bonus = m_fs - 1;
    m_score = m_score + pop + bonus;
    if (m_score > SMAX) m_score = SMAX;
    if (frame_start) m_fs = pop;
    else m_fs = m_fs + pop;
    if (m_fs > FSMAX) m_fs = FSMAX;
    sl = '0;
    for (int i = 0; i < NF; i++) sl[i] = (m_state[i] == 2);
    sb_q.push_back({sl, pulse, SW'(m_score)});
  endtask

  task automatic apply(input stim_t s);
    frame_start  = s.fs;
    fruit_active = s.act;
    fruit_new    = s.nw;
    cursor_pix   = s.cur ? 24'hFFFFFF : 24'h000000;
    for (int i = 0; i < NF; i++)
      fruit_pix[i*PW +: PW] = s.pix[i] ? (24'h000010 << i) : 24'h000000;
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    frame_start = 1'b0; cursor_pix = '0; fruit_pix = '0;
    fruit_active = '0; fruit_new = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    n_vec++;
    if ({sliced, slice_pulse, score} !== '0) begin
      n_err++;
      $display("FAIL reset: got sliced=%b pulse=%b score=%0d, expected all zero",
               sliced, slice_pulse, score);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_basic_slice();
    stim_t tbl [6];
    tbl = '{'{1'b0, 3'b001, 3'b001, 3'b001, 1'b1},
            '{1'b0, 3'b001, 3'b000, 3'b001, 1'b1},
            '{1'b0, 3'b001, 3'b000, 3'b001, 1'b1},
            '{1'b0, 3'b001, 3'b000, 3'b001, 1'b1},
            '{1'b0, 3'b001, 3'b000, 3'b001, 1'b1},
            '{1'b0, 3'b001, 3'b000, 3'b000, 1'b1}};
    for (int k = 0; k < 6; k++) begin
      apply(tbl[k]);
      exp_v = sb_q.pop_front();
      n_vec++;
      if ({sliced, slice_pulse, score} !== exp_v) begin
        n_err++;
        $display("FAIL basic step %0d: got %b %b %0d, expected %b %b %0d", k,
                 sliced, slice_pulse, score, exp_v[15:13], exp_v[12:10], exp_v[9:0]);
      end
      if (k == 3) begin
        n_vec++;
        if (slice_pulse !== 3'b000) begin
          n_err++;
          $display("FAIL basic_early: pulse=%b after 3 overlaps, expected 000", slice_pulse);
        end
      end
      if (k == 4) begin
        n_vec++;
        if (slice_pulse !== 3'b001 || sliced !== 3'b001 || score !== 10'd1) begin
          n_err++;
          $display("FAIL basic_hit: got pulse=%b sliced=%b score=%0d, expected 001 001 1",
                   slice_pulse, sliced, score);
        end
      end
      if (k == 5) begin
        n_vec++;
        if (slice_pulse !== 3'b000 || sliced !== 3'b001) begin
          n_err++;
          $display("FAIL basic_hold: got pulse=%b sliced=%b, expected 000 001",
                   slice_pulse, sliced);
        end
      end
    end
  endtask

  task automatic test_frame_clear();
    stim_t tbl [9];
    tbl = '{'{1'b0, 3'b001, 3'b001, 3'b000, 1'b1},
            '{1'b0, 3'b001, 3'b000, 3'b001, 1'b1},
            '{1'b0, 3'b001, 3'b000, 3'b001, 1'b1},
            '{1'b0, 3'b001, 3'b000, 3'b001, 1'b1},
            '{1'b1, 3'b001, 3'b000, 3'b000, 1'b1},
            '{1'b0, 3'b001, 3'b000, 3'b001, 1'b1},
            '{1'b0, 3'b001, 3'b000, 3'b001, 1'b1},
            '{1'b0, 3'b001, 3'b000, 3'b001, 1'b1},
            '{1'b0, 3'b001, 3'b000, 3'b001, 1'b1}};
    for (int k = 0; k < 9; k++) begin
      apply(tbl[k]);
      exp_v = sb_q.pop_front();
      n_vec++;
      if ({sliced, slice_pulse, score} !== exp_v) begin
        n_err++;
        $display("FAIL frame_clear step %0d: got %b %b %0d, expected %b %b %0d", k,
                 sliced, slice_pulse, score, exp_v[15:13], exp_v[12:10], exp_v[9:0]);
      end
      if (k == 7) begin
        n_vec++;
        if (slice_pulse !== 3'b000 || sliced !== 3'b000) begin
          n_err++;
          $display("FAIL frame_clear_noslice: got pulse=%b sliced=%b, expected 000 000",
                   slice_pulse, sliced);
        end
      end
      if (k == 8) begin
        n_vec++;
        if (slice_pulse !== 3'b001) begin
          n_err++;
          $display("FAIL frame_clear_slice: got pulse=%b, expected 001", slice_pulse);
        end
      end
    end
  endtask

  task automatic test_dual_slice();
    stim_t tbl [6];
    int    base;
    base = m_score;
    tbl = '{'{1'b1, 3'b101, 3'b101, 3'b000, 1'b1},
            '{1'b0, 3'b101, 3'b000, 3'b101, 1'b1},
            '{1'b0, 3'b101, 3'b000, 3'b101, 1'b1},
            '{1'b0, 3'b101, 3'b000, 3'b101, 1'b1},
            '{1'b0, 3'b101, 3'b000, 3'b101, 1'b1},
            '{1'b1, 3'b101, 3'b000, 3'b000, 1'b1}};
    for (int k = 0; k < 6; k++) begin
      apply(tbl[k]);
      exp_v = sb_q.pop_front();
      n_vec++;
      if ({sliced, slice_pulse, score} !== exp_v) begin
        n_err++;
        $display("FAIL dual step %0d: got %b %b %0d, expected %b %b %0d", k,
                 sliced, slice_pulse, score, exp_v[15:13], exp_v[12:10], exp_v[9:0]);
      end
      if (k == 4) begin
        n_vec++;
        if (slice_pulse !== 3'b101 || score !== SW'(base + 2)) begin
          n_err++;
          $display("FAIL dual_hit: got pulse=%b score=%0d, expected 101 %0d",
                   slice_pulse, score, base + 2);
        end
      end
      if (k == 5) begin
        n_vec++;
        if (score !== SW'(base + 2 + (COMBO ? 1 : 0))) begin
          n_err++;
          $display("FAIL dual_bonus: got score=%0d, expected %0d",
                   score, base + 2 + (COMBO ? 1 : 0));
        end
      end
    end
  endtask

  task automatic test_rearm_overlap();
    stim_t tbl [10];
    tbl = '{'{1'b0, 3'b010, 3'b010, 3'b000, 1'b1},
            '{1'b0, 3'b010, 3'b000, 3'b010, 1'b1},
            '{1'b0, 3'b010, 3'b000, 3'b010, 1'b1},
            '{1'b0, 3'b010, 3'b000, 3'b010, 1'b1},
            '{1'b0, 3'b010, 3'b000, 3'b010, 1'b1},
            '{1'b0, 3'b010, 3'b010, 3'b010, 1'b1},
            '{1'b0, 3'b010, 3'b000, 3'b010, 1'b1},
            '{1'b0, 3'b010, 3'b000, 3'b010, 1'b1},
            '{1'b0, 3'b010, 3'b000, 3'b010, 1'b1},
            '{1'b0, 3'b010, 3'b000, 3'b010, 1'b1}};
    for (int k = 0; k < 10; k++) begin
      apply(tbl[k]);
      exp_v = sb_q.pop_front();
      n_vec++;
      if ({sliced, slice_pulse, score} !== exp_v) begin
        n_err++;
        $display("FAIL rearm step %0d: got %b %b %0d, expected %b %b %0d", k,
                 sliced, slice_pulse, score, exp_v[15:13], exp_v[12:10], exp_v[9:0]);
      end
      if (k == 5) begin
        n_vec++;
        if (sliced[1] !== 1'b0 || slice_pulse !== 3'b000) begin
          n_err++;
          $display("FAIL rearm_clear: got sliced=%b pulse=%b, expected x0x 000",
                   sliced, slice_pulse);
        end
      end
      if (k == 8) begin
        n_vec++;
        if (slice_pulse !== 3'b000) begin
          n_err++;
          $display("FAIL rearm_count: got pulse=%b after 3 overlaps, expected 000", slice_pulse);
        end
      end
      if (k == 9) begin
        n_vec++;
        if (slice_pulse !== 3'b010) begin
          n_err++;
          $display("FAIL rearm_slice: got pulse=%b, expected 010", slice_pulse);
        end
      end
    end
  endtask

  task automatic test_drop();
    stim_t tbl [15];
    tbl = '{'{1'b0, 3'b001, 3'b001, 3'b000, 1'b1},
            '{1'b0, 3'b001, 3'b000, 3'b001, 1'b1},
            '{1'b0, 3'b001, 3'b000, 3'b001, 1'b1},
            '{1'b0, 3'b001, 3'b000, 3'b001, 1'b1},
            '{1'b0, 3'b000, 3'b000, 3'b001, 1'b1},
            '{1'b0, 3'b001, 3'b000, 3'b001, 1'b1},
            '{1'b0, 3'b001, 3'b000, 3'b001, 1'b1},
            '{1'b0, 3'b001, 3'b000, 3'b001, 1'b1},
            '{1'b0, 3'b001, 3'b000, 3'b001, 1'b1},
            '{1'b0, 3'b001, 3'b000, 3'b001, 1'b1},
            '{1'b0, 3'b001, 3'b001, 3'b001, 1'b1},
            '{1'b0, 3'b001, 3'b000, 3'b001, 1'b1},
            '{1'b0, 3'b001, 3'b000, 3'b001, 1'b1},
            '{1'b0, 3'b001, 3'b000, 3'b001, 1'b1},
            '{1'b0, 3'b001, 3'b000, 3'b001, 1'b1}};
    for (int k = 0; k < 15; k++) begin
      apply(tbl[k]);
      exp_v = sb_q.pop_front();
      n_vec++;
      if ({sliced, slice_pulse, score} !== exp_v) begin
        n_err++;
        $display("FAIL drop step %0d: got %b %b %0d, expected %b %b %0d", k,
                 sliced, slice_pulse, score, exp_v[15:13], exp_v[12:10], exp_v[9:0]);
      end
      if (k == 9) begin
        n_vec++;
        if (sliced !== 3'b000 || slice_pulse !== 3'b000) begin
          n_err++;
          $display("FAIL drop_idle: got sliced=%b pulse=%b, expected 000 000",
                   sliced, slice_pulse);
        end
      end
      if (k == 14) begin
        n_vec++;
        if (slice_pulse !== 3'b001) begin
          n_err++;
          $display("FAIL drop_rearm: got pulse=%b, expected 001", slice_pulse);
        end
      end
    end
  endtask

  task automatic test_saturation();
    stim_t s_new;
    stim_t s_hit;
    int    rounds;
    int    extra;
    s_new  = '{1'b0, 3'b111, 3'b111, 3'b000, 1'b1};
    s_hit  = '{1'b0, 3'b111, 3'b000, 3'b111, 1'b1};
    rounds = 0;
    extra  = 0;
    while (extra < 2 && rounds < 400) begin
      if (m_score >= SMAX) extra++;
      apply(s_new);
      exp_v = sb_q.pop_front();
      n_vec++;
      if ({sliced, slice_pulse, score} !== exp_v) begin
        n_err++;
        $display("FAIL sat round %0d rearm: got %b %b %0d, expected %b %b %0d", rounds,
                 sliced, slice_pulse, score, exp_v[15:13], exp_v[12:10], exp_v[9:0]);
      end
      for (int k = 0; k < TH; k++) begin
        apply(s_hit);
        exp_v = sb_q.pop_front();
        n_vec++;
        if ({sliced, slice_pulse, score} !== exp_v) begin
          n_err++;
          $display("FAIL sat round %0d hit %0d: got %b %b %0d, expected %b %b %0d", rounds, k,
                   sliced, slice_pulse, score, exp_v[15:13], exp_v[12:10], exp_v[9:0]);
        end
      end
      rounds++;
    end
    n_vec++;
    if (extra < 2 || score !== SW'(SMAX) || slice_pulse !== 3'b111) begin
      n_err++;
      $display("FAIL sat_hold: got score=%0d pulse=%b after %0d rounds, expected %0d 111",
               score, slice_pulse, rounds, SMAX);
    end
  endtask

  task automatic test_async_reset();
    stim_t tbl [3];
    stim_t s_idle_hit;
    tbl = '{'{1'b0, 3'b111, 3'b001, 3'b000, 1'b1},
            '{1'b0, 3'b111, 3'b000, 3'b001, 1'b1},
            '{1'b0, 3'b111, 3'b000, 3'b001, 1'b1}};
    for (int k = 0; k < 3; k++) begin
      apply(tbl[k]);
      exp_v = sb_q.pop_front();
      n_vec++;
      if ({sliced, slice_pulse, score} !== exp_v) begin
        n_err++;
        $display("FAIL areset pre step %0d: got %b %b %0d, expected %b %b %0d", k,
                 sliced, slice_pulse, score, exp_v[15:13], exp_v[12:10], exp_v[9:0]);
      end
    end
    // drop reset between edges: outputs must clear without a clock
    rst_n = 1'b0;
    #2;
    n_vec++;
    if ({sliced, slice_pulse, score} !== '0) begin
      n_err++;
      $display("FAIL areset_async: got sliced=%b pulse=%b score=%0d, expected all zero",
               sliced, slice_pulse, score);
    end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    // partial count must be gone and channels idle: overlap alone does nothing
    s_idle_hit = '{1'b0, 3'b001, 3'b000, 3'b001, 1'b1};
    for (int k = 0; k < 5; k++) begin
      apply(s_idle_hit);
      exp_v = sb_q.pop_front();
      n_vec++;
      if ({sliced, slice_pulse, score} !== exp_v) begin
        n_err++;
        $display("FAIL areset post step %0d: got %b %b %0d, expected %b %b %0d", k,
                 sliced, slice_pulse, score, exp_v[15:13], exp_v[12:10], exp_v[9:0]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_slice();
    test_frame_clear();
    test_dual_slice();
    test_rearm_overlap();
    test_drop();
    test_saturation();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/slice_tracker.md
Name: slice_tracker

Overview:
- Parametrised, N-channel successor to the per-fruit slice detector.
- Watches the cursor pixel stream against N fruit pixel streams and requires HIT_THRESH overlapping pixels within one video frame before declaring a slice. This debounce stops single-pixel grazes from counting.
- Holds a per-channel sliced level and emits a one-cycle slice pulse.
- Keeps a saturating game score. Sits between the sprite pixel generators and the game-control/scoring logic.

Parameters:
- NUM_FRUIT, 3, number of fruit channels (1..8).
- PIX_W, 24, pixel width in bits per stream.
- HIT_THRESH, 4, overlapping pixels per frame required to slice (1..255).
- SCORE_W, 10, score counter width.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- frame_start  in  1  one-cycle pulse at the start of each frame (vsync edge).
- cursor_pix  in  PIX_W  cursor sprite pixel; nonzero means the cursor is present.
- fruit_pix  in  NUM_FRUIT*PIX_W  fruit pixels; channel i occupies bits [i*PIX_W +: PIX_W].
- fruit_active  in  NUM_FRUIT  fruit i is on screen.
- fruit_new  in  NUM_FRUIT  fruit i respawned; re-arms the channel.
- sliced  out  NUM_FRUIT  level; channel is in the SLICED state.
- slice_pulse  out  NUM_FRUIT  one-cycle pulse on entry to SLICED.
- score  out  SCORE_W  saturating total of slices.

Behaviour:
- Reset (async, rst_n=0):
  - All channels go to IDLE.
  - hit_cnt, sliced, slice_pulse, score and frame_slices all become 0.
  - Release takes effect on the first clk edge with rst_n=1.
- Overlap for channel i: ovl[i] = (|cursor_pix) & (|fruit_pix[i]) & fruit_active[i].
- Per-channel FSM. States are IDLE, ARMED and SLICED. Conditions are evaluated in the priority order listed.
- Priority rules that apply from any state:
  - fruit_active[i]=0 → IDLE, hit_cnt=0.
  - Else fruit_new[i]=1 → ARMED, hit_cnt=0. Overlap in this same cycle is ignored.
- IDLE:
  - Stays in IDLE. Leaves only through fruit_new with fruit_active.
- ARMED:
  - On frame_start: hit_cnt = ovl[i] ? 1 : 0.
  - Otherwise: hit_cnt += ovl[i].
  - If the updated count reaches HIT_THRESH: → SLICED, and slice_pulse[i]=1 for exactly one cycle.
  - hit_cnt width is clog2(HIT_THRESH+1) and never exceeds HIT_THRESH.
- SLICED:
  - Ignores overlap and frame_start.
  - Holds until fruit_new&fruit_active (→ ARMED) or fruit_active drops (→ IDLE).
- Outputs are registered:
  - sliced[i] = (state==SLICED).
  - Latency: the HIT_THRESH-th overlapping pixel at edge t gives sliced=1 and slice_pulse=1 visible after edge t.
- Score:
  - Each cycle, score += popcount(slice_pulse_next), i.e. counted in the same edge that raises the pulse.
  - Saturates at 2^SCORE_W-1 and never wraps.
  - Simultaneous slices on several channels all count.
- frame_slices:
  - Counts slice entries since the last frame_start. Width clog2(NUM_FRUIT+1)+1, saturating.
  - Cleared on frame_start; slices in that same cycle then load the count.
- Reset mid-frame discards all partial counts. There is no recovery of in-progress slices.

Optional Feature:
- Macro COMBO_BONUS_EN.
- Defined:
  - On frame_start, if frame_slices ≥ 2, score additionally gains frame_slices−1.
  - Same saturation rule applies.
  - This bonus and any same-cycle slice pulses are both added in that edge.
- Undefined:
  - No bonus. frame_slices logic may be removed. score counts slices only.

Test Plan:
- Reset, then fruit_active=3'b001, fruit_new pulse on ch0, cursor_pix=24'hFFFFFF, fruit_pix ch0 nonzero for 4 consecutive cycles (HIT_THRESH=4) → slice_pulse=3'b001 for 1 cycle after 4th edge, sliced[0]=1 held, score=1.
- ch0 armed: 3 overlap pixels, frame_start, 3 more → no slice. 4th overlap after frame_start → slice. Confirms per-frame clearing.
- ch0 and ch2 reach threshold on the same edge → slice_pulse=3'b101, score +2. With COMBO_BONUS_EN, the next frame_start adds +1 (score=3).
- ch1 SLICED, fruit_new[1]=1 with overlap in the same cycle → ARMED, hit_cnt=0, sliced[1]=0 next cycle.
- fruit_active[0] dropped while hit_cnt=3 → IDLE. Further overlap causes no slice until fruit_new.
- SCORE_W=3, score=7, one more slice → score stays 7. rst_n asserted mid-count → all outputs 0 immediately (async).
